// File: rtl/dsp_post_adder_acc.sv
// Post-adder / accumulator stage of the DSP48A1 slice: X/Z operand select, add/subtract with carry-in,
// 48-bit P accumulator plus carry-out register.
module dsp_post_adder_acc #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int CARRYINREG  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic [3:0]  OPMODE,
  input  logic        SUB,
  input  logic        CARRYIN,
  input  logic [35:0] M,
  input  logic [47:0] DAB,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [47:0] p_reg_q, p_reg_d;
  logic        cy_q, cy_d;
  logic        cin_q, cin_d;

  logic        cin;
  logic [47:0] x_op, z_op;
  logic [48:0] x_ext, sum;

  always_comb begin
    cin = (CARRYINREG != 0) ? cin_q : CARRYIN;

    x_op = '0;
    unique case (OPMODE[1:0])
      2'd0: x_op = '0;
      2'd1: x_op = {12'd0, M};
      2'd2: x_op = p_reg_q;
      2'd3: x_op = DAB;
    endcase

    z_op = '0;
    unique case (OPMODE[3:2])
      2'd0: z_op = '0;
      2'd1: z_op = PCIN;
      2'd2: z_op = p_reg_q;
      2'd3: z_op = C;
    endcase

    // 49-bit arithmetic: bit 48 is carry on add, borrow on subtract
    x_ext = {1'b0, x_op} + {48'd0, cin};
    sum   = SUB ? ({1'b0, z_op} - x_ext) : ({1'b0, z_op} + x_ext);
  end

  always_comb begin
    p_reg_d = p_reg_q;
    cy_d    = cy_q;
    cin_d   = cin_q;
    if (CEP) begin
      p_reg_d = sum[47:0];
      cy_d    = sum[48];
    end
    if (CECARRYIN) begin
      cin_d = CARRYIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_reg_q <= '0;
      cy_q    <= 1'b0;
      cin_q   <= 1'b0;
    end else begin
      p_reg_q <= p_reg_d;
      cy_q    <= cy_d;
      cin_q   <= cin_d;
    end
  end

  // Feedback always uses p_reg_q, so the unregistered output mode has no combinational loop
  always_comb begin
    P         = (PREG != 0) ? p_reg_q : sum[47:0];
    PCOUT     = P;
    CARRYOUT  = (CARRYOUTREG != 0) ? cy_q : sum[48];
    CARRYOUTF = CARRYOUT;
  end

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed self-checking bench for dsp_post_adder_acc: a registered-output instance and an
// unregistered-output instance share one set of stimulus.
module tb_dsp_post_adder_acc;

  logic        CLK = 1'b0;
  logic        RST, CEP, CECARRYIN, SUB, CARRYIN;
  logic [3:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;

  logic [47:0] p_r, pcout_r, p_c, pcout_c;
  logic        co_r, cof_r, co_c, cof_c;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dsp_post_adder_acc #(.PREG(1), .CARRYOUTREG(1), .CARRYINREG(1)) u_dut_reg (
    .CLK(CLK), .RST(RST), .CEP(CEP), .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .SUB(SUB),
    .CARRYIN(CARRYIN), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(p_r), .PCOUT(pcout_r), .CARRYOUT(co_r), .CARRYOUTF(cof_r)
  );

  dsp_post_adder_acc #(.PREG(0), .CARRYOUTREG(0), .CARRYINREG(1)) u_dut_comb (
    .CLK(CLK), .RST(RST), .CEP(CEP), .CECARRYIN(CECARRYIN), .OPMODE(OPMODE), .SUB(SUB),
    .CARRYIN(CARRYIN), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(p_c), .PCOUT(pcout_c), .CARRYOUT(co_c), .CARRYOUTF(cof_c)
  );

  task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset with busy, non-zero inputs
    RST = 1'b1; CEP = 1'b1; CECARRYIN = 1'b1; CARRYIN = 1'b1; SUB = 1'b0;
    OPMODE = 4'b1111; M = 36'd123; DAB = 48'h1234_5678_9ABC; C = 48'h0F0F_0F0F_0F0F;
    PCIN = 48'hAAAA_5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_p",     {1'b0, p_r},     49'd0);
      chk("rst_pcout", {1'b0, pcout_r}, 49'd0);
      chk("rst_co",    {48'd0, co_r},   49'd0);
      chk("rst_cof",   {48'd0, cof_r},  49'd0);
    end

    // accumulate Z=P, X=M, M=5
    RST = 1'b0; CARRYIN = 1'b0; OPMODE = 4'b1001; M = 36'd5;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("acc_comb_p", {1'b0, p_c}, 49'(5 * k));
      tick();
      chk("acc_p",     {1'b0, p_r},     49'(5 * k));
      chk("acc_pcout", {1'b0, pcout_r}, 49'(5 * k));
    end

    // subtract with borrow: 3 - 5
    OPMODE = 4'b1111; C = 48'd3; DAB = 48'd5; SUB = 1'b1;
    #1;
    chk("sub_comb_co", {48'd0, co_c}, 49'd1);
    tick();
    chk("sub_p",   {1'b0, p_r},    {1'b0, 48'hFFFF_FFFF_FFFE});
    chk("sub_co",  {48'd0, co_r},  49'd1);
    chk("sub_cof", {48'd0, cof_r}, 49'd1);

    // overflow: all-ones + 1
    OPMODE = 4'b1101; C = 48'hFFFF_FFFF_FFFF; M = 36'd1; SUB = 1'b0;
    tick();
    chk("ovf_p",  {1'b0, p_r},   49'd0);
    chk("ovf_co", {48'd0, co_r}, 49'd1);

    // CEP low holds registers; unregistered instance still follows the adder
    CEP = 1'b0; C = 48'd100; M = 36'd3;
    #1;
    chk("hold_comb_p",  {1'b0, p_c},   49'd103);
    chk("hold_comb_co", {48'd0, co_c}, 49'd0);
    tick();
    chk("hold_p",  {1'b0, p_r},   49'd0);
    chk("hold_co", {48'd0, co_r}, 49'd1);

    // carry-in register: load 1 once, then hold it
    CEP = 1'b1; CECARRYIN = 1'b1; CARRYIN = 1'b1; OPMODE = 4'b1100; C = 48'd10;
    tick();
    chk("cin_first_p", {1'b0, p_r}, 49'd10);
    CECARRYIN = 1'b0; CARRYIN = 1'b0;
    #1;
    chk("cin_comb_p", {1'b0, p_c}, 49'd11);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("cin_p",  {1'b0, p_r},   49'd11);
      chk("cin_co", {48'd0, co_r}, 49'd0);
    end

    // reset with CEP low still clears (also clears carry-in register)
    RST = 1'b1; CEP = 1'b0;
    tick();
    chk("rst_cep0_p", {1'b0, p_r}, 49'd0);

    // accumulate M=7 to 21, then reset mid-accumulation with CEP high
    RST = 1'b0; CEP = 1'b1; OPMODE = 4'b1001; M = 36'd7;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("acc7_p", {1'b0, p_r}, 49'(7 * k));
    end
    RST = 1'b1;
    tick();
    chk("midrst_p",      {1'b0, p_r}, 49'd0);
    chk("midrst_comb_p", {1'b0, p_c}, 49'd7);
    RST = 1'b0;
    tick();
    chk("post_rst_p",      {1'b0, p_r}, 49'd7);
    chk("post_rst_comb_p", {1'b0, p_c}, 49'd14);

    // X=P and Z=P together doubles the accumulator
    OPMODE = 4'b1010;
    tick();
    chk("dbl_p", {1'b0, p_r}, 49'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
